mdu_e: RTL and testbench
========================

# mdu_e

Execute-stage multiply/divide unit for the five-stage MIPS pipeline, downstream of the D/E pipeline register. It consumes the forwarded rs/rt operands and a decoded op, and runs multi-cycle signed/unsigned mult and div into private HI/LO registers. It also services mthi/mtlo and exposes `busy`; the hazard unit uses `busy` to stall any multiply/divide-class instruction in D.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy duration of mult/multu (and madd/maddu); legal range ≥ 1.
- `DIV_CYCLES`, default 10: busy duration of div/divu; legal range ≥ 1.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  E-stage instruction is an MDU op; sampled at the rising edge.
- `md_op`  in  3  operation: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 madd, 111 maddu.
- `A`  in  32  forwarded rs value.
- `B`  in  32  forwarded rt value.
- `busy`  out  1  an operation is in progress.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE (`busy`=0) and BUSY (`busy`=1). A down-counter `cnt` drives the state: BUSY ⇔ `cnt`≠0.
- In IDLE, `start`=1 with a mult-class op:
  - Compute the full 64-bit result from A/B at that edge and hold it in an internal pending register.
  - Load `cnt`=MULT_CYCLES.
- In IDLE, `start`=1 with a div-class op: same as mult, but load `cnt`=DIV_CYCLES.
- Each edge in BUSY decrements `cnt`. On the edge where `cnt` goes 1→0, write the pending result to hi/lo and clear `busy`.
- mult: signed 64-bit product; hi = [63:32], lo = [31:0].
- multu: unsigned 64-bit product; hi = [63:32], lo = [31:0].
- div/divu:
  - lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- B=0 for div/divu: the unit still goes BUSY for DIV_CYCLES, then leaves hi/lo unchanged.
- mthi/mtlo in IDLE: hi (or lo) ← A at the same edge. No BUSY state entered.
- `start` while BUSY is ignored entirely, including mthi/mtlo. The hazard unit guarantees this does not occur; the bench still checks that it is ignored.
- hi/lo hold their old values throughout BUSY.
- `reset`:
  - hi=0, lo=0, `busy`=0, `cnt`=0; the pending result is discarded.
  - Reset has priority over `start` and over an in-flight completion.

## Timing
- `start` high in cycle T (IDLE) gives:
  - `busy`=1 in cycles T+1 … T+N, where N = MULT_CYCLES or DIV_CYCLES.
  - hi/lo carry the new value from cycle T+N+1, the same edge that drops `busy`.
- `start` in cycle T+N+1 is accepted, so back-to-back ops are allowed with no gap cycle.
- mthi/mtlo in cycle T: the new value is visible in cycle T+1.
- `busy`, `hi` and `lo` are registered outputs with no combinational path from inputs.
- Reset asserted in any cycle: all outputs read 0 in the next cycle.

## Configuration
- Macro: `MDU_MADD_EN`.
- Defined:
  - md_op 110 (madd): {hi,lo} ← {hi,lo} + signed(A×B), modulo 2^64.
  - md_op 111 (maddu): same, with an unsigned product.
  - The accumulator base is the hi/lo value at the start edge.
  - Both ops use MULT_CYCLES and complete like mult.
- Undefined: md_op 110/111 with `start`=1 is a no-op; no BUSY, hi/lo unchanged.

## Test plan
- Reset then idle: `reset`=1 for 1 cycle → `busy`=0, hi=0, lo=0.
- mult, A=0xFFFFFFFE, B=3 → `busy` high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- div, A=0xFFFFFFF9 (−7), B=2 → `busy` high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Follow with divu A=5, B=0 → after 10 busy cycles, hi/lo are still 0xFFFFFFFF/0xFFFFFFFD.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on consecutive cycles → hi=0x12345678 and lo=0x9ABCDEF0 one cycle after each; `busy` stays 0.
- mult A=2, B=3, then:
  - `start`/mtlo with A=7 on busy cycle 2 → ignored; final lo=6.
  - Restart the same mult and assert reset on busy cycle 3 → next cycle `busy`=0, hi=lo=0; no late write follows.
- With `MDU_MADD_EN`: hi=0, lo=0xFFFFFFFF, then maddu A=1, B=1 → hi=1, lo=0 after 5 busy cycles. Without the macro, the same stimulus leaves `busy`=0 and hi/lo unchanged.

Source files
------------

// File: rtl/mdu_e_if.sv
// Operand/result bundle between the E-stage datapath and the multiply/divide unit.
interface mdu_e_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, md_op, A, B, input busy, hi, lo);
  modport slave  (input start, md_op, A, B, output busy, hi, lo);
endinterface

// File: rtl/mdu_e.sv
// Multi-cycle multiply/divide unit with private HI/LO for the E stage.
// Optional madd/maddu accumulate ops are enabled by defining MDU_MADD_EN.
//
//   state | meaning
//   IDLE  | accepts start; mthi/mtlo write immediately
//   BUSY  | cnt counts down; pending result lands on hi/lo at 1->0
module mdu_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic  clk,
  input  logic  reset,
  mdu_e_if.slave bus
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      pend;
  logic             pend_wr;
  logic             busy_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  assign prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
  assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};

  // Divide on magnitudes so that 0x80000000 / -1 wraps cleanly instead of overflowing.
  logic        div_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] div_d;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quo;
  logic [31:0] rem;

  assign div_signed = (bus.md_op == 3'b010);
  assign a_neg      = div_signed & bus.A[31];
  assign b_neg      = div_signed & bus.B[31];
  assign a_mag      = a_neg ? (32'd0 - bus.A) : bus.A;
  assign b_mag      = b_neg ? (32'd0 - bus.B) : bus.B;
  assign div_d      = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign uq         = a_mag / div_d;
  assign ur         = a_mag % div_d;
  assign quo        = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
  assign rem        = a_neg ? (32'd0 - ur) : ur;

  logic        op_mul;
  logic        op_div;
  logic        op_mthi;
  logic        op_mtlo;
  logic [63:0] res;
  logic        res_wr;

  always_comb begin
    op_mul  = 1'b0;
    op_div  = 1'b0;
    op_mthi = 1'b0;
    op_mtlo = 1'b0;
    res     = prod_s;
    res_wr  = 1'b1;
    case (bus.md_op)
      3'b000: begin op_mul = 1'b1; res = prod_s; end
      3'b001: begin op_mul = 1'b1; res = prod_u; end
      3'b010, 3'b011: begin
        op_div = 1'b1;
        res    = {rem, quo};
        res_wr = (bus.B != 32'd0);
      end
      3'b100: op_mthi = 1'b1;
      3'b101: op_mtlo = 1'b1;
`ifdef MDU_MADD_EN
      3'b110: begin op_mul = 1'b1; res = {hi_q, lo_q} + prod_s; end
      3'b111: begin op_mul = 1'b1; res = {hi_q, lo_q} + prod_u; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend    <= '0;
      pend_wr <= 1'b0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (op_mul || op_div) begin
              state   <= BUSY;
              busy_q  <= 1'b1;
              cnt     <= op_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
              pend    <= res;
              pend_wr <= res_wr;
            end else if (op_mthi) begin
              hi_q <= bus.A;
            end else if (op_mtlo) begin
              lo_q <= bus.A;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            if (pend_wr) {hi_q, lo_q} <= pend;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_e.sv
// Self-checking bench for mdu_e: directed cases plus random ops against an arithmetic model.
module tb_mdu_e;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  mdu_e_if mif();

  mdu_e #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (.clk(clk), .reset(reset), .bus(mif));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  function automatic int exp_cycles(input logic [2:0] op);
    case (op)
      3'b000, 3'b001: return MC;
      3'b010, 3'b011: return DC;
`ifdef MDU_MADD_EN
      3'b110, 3'b111: return MC;
`endif
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p, acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'b000: begin p = 64'(sa * sb); {m_hi, m_lo} = p; end
      3'b001: begin p = 64'(a) * 64'(b); {m_hi, m_lo} = p; end
      3'b010: if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
      3'b011: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      3'b100: m_hi = a;
      3'b101: m_lo = a;
`ifdef MDU_MADD_EN
      3'b110: begin acc = {m_hi, m_lo} + 64'(sa * sb); {m_hi, m_lo} = acc; end
      3'b111: begin acc = {m_hi, m_lo} + 64'(a) * 64'(b); {m_hi, m_lo} = acc; end
`endif
      default: ;
    endcase
  endtask

  // Issue one op (called #1 after a rising edge) and return busy length and whether hi/lo held.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int nb, output bit held);
    logic [31:0] h0, l0;
    h0 = mif.hi;
    l0 = mif.lo;
    mif.start = 1'b1;
    mif.md_op = op;
    mif.A = a;
    mif.B = b;
    @(posedge clk); #1;
    mif.start = 1'b0;
    nb = 0;
    held = 1'b1;
    while (mif.busy === 1'b1 && nb < 200) begin
      nb++;
      if (mif.hi !== h0 || mif.lo !== l0) held = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    int nb; bit held;
    do_op(3'b100, 32'hDEADBEEF, 32'd0, nb, held);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = 0; m_lo = 0;
    total++; if (mif.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", mif.busy); end
    total++; if (mif.hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=0", mif.hi); end
    total++; if (mif.lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=0", mif.lo); end
  endtask

  task automatic test_mult();
    int nb; bit held;
    do_op(3'b000, 32'hFFFFFFFE, 32'd3, nb, held);
    model_step(3'b000, 32'hFFFFFFFE, 32'd3);
    total++; if (nb != MC) begin bad++; $display("FAIL mult_busy got=%0d want=%0d", nb, MC); end
    total++; if (!held) begin bad++; $display("FAIL mult_hold got=changed want=held"); end
    total++; if (mif.hi !== 32'hFFFFFFFF || mif.lo !== 32'hFFFFFFFA)
      begin bad++; $display("FAIL mult_res got=%h_%h want=ffffffff_fffffffa", mif.hi, mif.lo); end
    do_op(3'b001, 32'hFFFFFFFE, 32'd3, nb, held);
    model_step(3'b001, 32'hFFFFFFFE, 32'd3);
    total++; if (nb != MC) begin bad++; $display("FAIL multu_busy got=%0d want=%0d", nb, MC); end
    total++; if (mif.hi !== 32'h00000002 || mif.lo !== 32'hFFFFFFFA)
      begin bad++; $display("FAIL multu_res got=%h_%h want=00000002_fffffffa", mif.hi, mif.lo); end
  endtask

  task automatic test_div();
    int nb; bit held;
    do_op(3'b010, 32'hFFFFFFF9, 32'd2, nb, held);
    model_step(3'b010, 32'hFFFFFFF9, 32'd2);
    total++; if (nb != DC) begin bad++; $display("FAIL div_busy got=%0d want=%0d", nb, DC); end
    total++; if (!held) begin bad++; $display("FAIL div_hold got=changed want=held"); end
    total++; if (mif.hi !== 32'hFFFFFFFF || mif.lo !== 32'hFFFFFFFD)
      begin bad++; $display("FAIL div_res got=%h_%h want=ffffffff_fffffffd", mif.hi, mif.lo); end
    do_op(3'b011, 32'd5, 32'd0, nb, held);
    model_step(3'b011, 32'd5, 32'd0);
    total++; if (nb != DC) begin bad++; $display("FAIL divz_busy got=%0d want=%0d", nb, DC); end
    total++; if (mif.hi !== 32'hFFFFFFFF || mif.lo !== 32'hFFFFFFFD)
      begin bad++; $display("FAIL divz_res got=%h_%h want=ffffffff_fffffffd", mif.hi, mif.lo); end
    do_op(3'b010, 32'h80000000, 32'hFFFFFFFF, nb, held);
    model_step(3'b010, 32'h80000000, 32'hFFFFFFFF);
    total++; if (mif.hi !== 32'd0 || mif.lo !== 32'h80000000)
      begin bad++; $display("FAIL div_ovf got=%h_%h want=00000000_80000000", mif.hi, mif.lo); end
  endtask

  task automatic test_mthi_mtlo();
    mif.start = 1'b1; mif.md_op = 3'b100; mif.A = 32'h12345678; mif.B = 32'd0;
    @(posedge clk); #1;
    total++; if (mif.hi !== 32'h12345678 || mif.busy !== 1'b0)
      begin bad++; $display("FAIL mthi got=%h busy=%b want=12345678 busy=0", mif.hi, mif.busy); end
    mif.md_op = 3'b101; mif.A = 32'h9ABCDEF0;
    @(posedge clk); #1;
    mif.start = 1'b0;
    model_step(3'b100, 32'h12345678, 32'd0);
    model_step(3'b101, 32'h9ABCDEF0, 32'd0);
    total++; if (mif.lo !== 32'h9ABCDEF0 || mif.hi !== 32'h12345678 || mif.busy !== 1'b0)
      begin bad++; $display("FAIL mtlo got=%h_%h busy=%b want=12345678_9abcdef0 busy=0", mif.hi, mif.lo, mif.busy); end
  endtask

  task automatic test_ignore_busy();
    int nb;
    mif.start = 1'b1; mif.md_op = 3'b000; mif.A = 32'd2; mif.B = 32'd3;
    @(posedge clk); #1;
    mif.start = 1'b0;
    @(posedge clk); #1;
    mif.start = 1'b1; mif.md_op = 3'b101; mif.A = 32'd7;
    @(posedge clk); #1;
    mif.start = 1'b0;
    nb = 2;
    while (mif.busy === 1'b1 && nb < 200) begin nb++; @(posedge clk); #1; end
    model_step(3'b000, 32'd2, 32'd3);
    total++; if (nb != MC) begin bad++; $display("FAIL ign_busy got=%0d want=%0d", nb, MC); end
    total++; if (mif.lo !== 32'd6 || mif.hi !== 32'd0)
      begin bad++; $display("FAIL ign_res got=%h_%h want=00000000_00000006", mif.hi, mif.lo); end
  endtask

  task automatic test_reset_abort();
    bit late;
    mif.start = 1'b1; mif.md_op = 3'b000; mif.A = 32'd2; mif.B = 32'd3;
    @(posedge clk); #1;
    mif.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = 0; m_lo = 0;
    total++; if (mif.busy !== 1'b0 || mif.hi !== 32'd0 || mif.lo !== 32'd0)
      begin bad++; $display("FAIL abort got=%h_%h busy=%b want=0_0 busy=0", mif.hi, mif.lo, mif.busy); end
    late = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (mif.busy !== 1'b0 || mif.hi !== 32'd0 || mif.lo !== 32'd0) late = 1'b1;
    end
    total++; if (late) begin bad++; $display("FAIL abort_late got=write want=none"); end
  endtask

  task automatic test_madd();
    int nb; bit held;
    do_op(3'b100, 32'd0, 32'd0, nb, held);
    do_op(3'b101, 32'hFFFFFFFF, 32'd0, nb, held);
    model_step(3'b100, 32'd0, 32'd0);
    model_step(3'b101, 32'hFFFFFFFF, 32'd0);
    do_op(3'b111, 32'd1, 32'd1, nb, held);
    model_step(3'b111, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    total++; if (nb != MC) begin bad++; $display("FAIL maddu_busy got=%0d want=%0d", nb, MC); end
    total++; if (mif.hi !== 32'd1 || mif.lo !== 32'd0)
      begin bad++; $display("FAIL maddu_res got=%h_%h want=00000001_00000000", mif.hi, mif.lo); end
`else
    total++; if (nb != 0) begin bad++; $display("FAIL maddu_busy got=%0d want=0", nb); end
    total++; if (mif.hi !== 32'd0 || mif.lo !== 32'hFFFFFFFF)
      begin bad++; $display("FAIL maddu_res got=%h_%h want=00000000_ffffffff", mif.hi, mif.lo); end
`endif
  endtask

  task automatic test_random();
    int nb; bit held;
    logic [2:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
      if ($urandom_range(0, 3) == 0) b = b & 32'hF;
      do_op(op, a, b, nb, held);
      model_step(op, a, b);
      total++; if (nb != exp_cycles(op))
        begin bad++; $display("FAIL rnd_busy op=%0d got=%0d want=%0d", op, nb, exp_cycles(op)); end
      total++; if (mif.hi !== m_hi || mif.lo !== m_lo)
        begin bad++; $display("FAIL rnd_res op=%0d a=%h b=%h got=%h_%h want=%h_%h", op, a, b, mif.hi, mif.lo, m_hi, m_lo); end
      total++; if (!held) begin bad++; $display("FAIL rnd_hold op=%0d got=changed want=held", op); end
    end
  endtask

  task automatic test_back_to_back();
    int nb1, nb2; bit h1, h2;
    do_op(3'b001, 32'd100, 32'd7, nb1, h1);
    model_step(3'b001, 32'd100, 32'd7);
    do_op(3'b011, 32'd100, 32'd7, nb2, h2);
    model_step(3'b011, 32'd100, 32'd7);
    total++; if (nb1 != MC || nb2 != DC)
      begin bad++; $display("FAIL b2b_busy got=%0d,%0d want=%0d,%0d", nb1, nb2, MC, DC); end
    total++; if (mif.hi !== 32'd2 || mif.lo !== 32'd14 || mif.hi !== m_hi || mif.lo !== m_lo)
      begin bad++; $display("FAIL b2b_res got=%h_%h want=00000002_0000000e", mif.hi, mif.lo); end
  endtask

  initial begin
    mif.start = 1'b0;
    mif.md_op = 3'b000;
    mif.A = 32'd0;
    mif.B = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_ignore_busy();
    test_reset_abort();
    test_madd();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
